// File: rtl/sysctrl_pkg.sv
// Shared definitions for both ends of the byte-serial system-control link.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sysctrl_pkg;

    // Command codes carried in the start byte of every frame
    localparam logic [7:0] CMD_STATUS  = 8'd0;
    localparam logic [7:0] CMD_LEDS    = 8'd1;
    localparam logic [7:0] CMD_COLOR   = 8'd2;
    localparam logic [7:0] CMD_BUTTONS = 8'd3;
    localparam logic [7:0] CMD_CONFIG  = 8'd4;
    localparam logic [7:0] CMD_INT     = 8'd5;

    // First two bytes a responder returns to a status frame
    localparam logic [7:0] STATUS_MAGIC0 = 8'h5c;
    localparam logic [7:0] STATUS_MAGIC1 = 8'h42;

    // Gap timer width: wide enough for the 16-cycle interrupt holdoff
    localparam int          TMR_W          = 5;
    localparam logic [4:0]  HOLDOFF_CYCLES = 5'd16;

    // Which kind of frame the host is currently running
    localparam logic [1:0] SVC_NONE = 2'd0;
    localparam logic [1:0] SVC_POLL = 2'd1;
    localparam logic [1:0] SVC_ACK  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_GAP,
        ST_BYTE,
        ST_DONE,
        ST_IRQ_ACK0,
        ST_IRQ_ACK1,
        ST_HOLDOFF
    } host_state_e;

endpackage

// File: rtl/sysctrl_host_gap_timer.sv
// Loadable down-counter timing the idle clocks after each strobe.
// Latency: load value N gives N counting cycles; last_gap_o on the Nth.
// Backpressure: none; reload wins over counting.
module sysctrl_host_gap_timer
    import sysctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             gap_done_o,
    output logic             last_gap_o
);

    logic [TMR_W-1:0] cnt_q;

    // Count down to zero after each load, then hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign gap_done_o = (cnt_q == '0);
    assign last_gap_o = (cnt_q == TMR_W'(1));

endmodule

// File: rtl/sysctrl_host.sv
// Link initiator: serialises request frames as strobe/start/data, returns sampled bytes.
// Latency: command strobe 1 cycle after accept, rsp_valid at accept+1+(len+1)*(STROBE_GAP+1).
// Backpressure: req_ready low from accept through DONE; rsp_valid is never stalled.
// Optional interrupt polling enabled by defining SYSCTRL_HOST_IRQ_POLL_EN.
module sysctrl_host
    import sysctrl_pkg::*;
#(
    parameter int STROBE_GAP = 2,
    parameter int MAX_LEN    = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [7:0]           req_cmd,
    input  logic [3:0]           req_len,
    input  logic [8*MAX_LEN-1:0] req_data,
    output logic                 rsp_valid,
    output logic [8*MAX_LEN-1:0] rsp_data,
    output logic                 sys_strobe,
    output logic                 sys_start,
    output logic [7:0]           sys_data,
    input  logic [7:0]           sys_data_in,
    input  logic                 sys_int_n,
    output logic                 irq_valid,
    output logic [7:0]           irq_status
);

    localparam logic [3:0]       MAX_LEN_L = 4'(MAX_LEN);
    localparam logic [TMR_W-1:0] GAP_L     = TMR_W'(STROBE_GAP);

    host_state_e          state_q;
    logic [3:0]           len_q;
    logic [8*MAX_LEN-1:0] data_q;
    logic [3:0]           idx_q;      // next payload byte to strobe
    logic                 pay_q;      // last strobe carried payload, so a return byte is due
    logic                 req_ready_q;
    logic                 rsp_valid_q;
    logic [8*MAX_LEN-1:0] rsp_data_q;
    logic                 strobe_q;
    logic                 start_q;
    logic [7:0]           sys_data_q;

    logic                 tmr_load;
    logic [TMR_W-1:0]     tmr_val;
    logic                 gap_done;
    logic                 last_gap;
    logic                 gap_end;
    logic [7:0]           next_byte;
    logic [3:0]           ret_idx;
    logic [3:0]           clamp_len;
    logic                 is_req_frame;

`ifdef SYSCTRL_HOST_IRQ_POLL_EN
    logic [1:0]           svc_q;
    logic [7:0]           irq_s_q;
    logic                 irq_valid_q;
    logic [7:0]           irq_status_q;

    assign is_req_frame = (svc_q == SVC_NONE);
    // A pending interrupt pre-empts requests in the same cycle
    assign req_ready    = req_ready_q & sys_int_n;
    assign irq_valid    = irq_valid_q;
    assign irq_status   = irq_status_q;
`else
    logic unused_int_n;

    assign is_req_frame = 1'b1;
    assign req_ready    = req_ready_q;
    assign irq_valid    = 1'b0;
    assign irq_status   = 8'h00;
    assign unused_int_n = sys_int_n;
`endif

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign sys_strobe = strobe_q;
    assign sys_start  = start_q;
    assign sys_data   = sys_data_q;

    assign clamp_len = (req_len > MAX_LEN_L) ? MAX_LEN_L : req_len;
    assign ret_idx   = idx_q - 4'd1;
    // Defensive: a zero counter also ends the gap so the FSM can never stall
    assign gap_end   = last_gap | gap_done;

    // Select the payload byte that goes out on the next strobe
    always_comb begin
        next_byte = 8'h00;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (k[3:0] == idx_q) begin
                next_byte = data_q[8*k +: 8];
            end
        end
    end

    // Restart the gap timer on every strobe cycle (and for the interrupt holdoff)
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = GAP_L;
        if (state_q == ST_CMD || state_q == ST_BYTE) begin
            tmr_load = 1'b1;
        end
`ifdef SYSCTRL_HOST_IRQ_POLL_EN
        if (state_q == ST_IRQ_ACK1) begin
            tmr_load = 1'b1;
            tmr_val  = HOLDOFF_CYCLES;
        end
`endif
    end

    sysctrl_host_gap_timer u_gap_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .gap_done_o (gap_done),
        .last_gap_o (last_gap)
    );

    // Frame sequencer with registered link and handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            data_q      <= '0;
            idx_q       <= '0;
            pay_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            strobe_q    <= 1'b0;
            start_q     <= 1'b0;
            sys_data_q  <= 8'h00;
`ifdef SYSCTRL_HOST_IRQ_POLL_EN
            svc_q        <= SVC_NONE;
            irq_s_q      <= 8'h00;
            irq_valid_q  <= 1'b0;
            irq_status_q <= 8'h00;
`endif
        end else begin
            strobe_q    <= 1'b0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifdef SYSCTRL_HOST_IRQ_POLL_EN
            irq_valid_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
`ifdef SYSCTRL_HOST_IRQ_POLL_EN
                    if (!sys_int_n) begin
                        // Poll frame: read the pending interrupt bits
                        len_q       <= 4'd1;
                        data_q      <= '0;
                        idx_q       <= '0;
                        pay_q       <= 1'b0;
                        strobe_q    <= 1'b1;
                        start_q     <= 1'b1;
                        sys_data_q  <= CMD_INT;
                        svc_q       <= SVC_POLL;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_CMD;
                    end else
`endif
                    if (req_valid) begin
                        len_q       <= clamp_len;
                        data_q      <= req_data;
                        rsp_data_q  <= '0;
                        idx_q       <= '0;
                        pay_q       <= 1'b0;
                        strobe_q    <= 1'b1;
                        start_q     <= 1'b1;
                        sys_data_q  <= req_cmd;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_CMD;
                    end
                end
                ST_CMD, ST_BYTE: begin
                    state_q <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_end) begin
                        if (pay_q) begin
                            if (is_req_frame) begin
                                for (int k = 0; k < MAX_LEN; k++) begin
                                    if (k[3:0] == ret_idx) begin
                                        rsp_data_q[8*k +: 8] <= sys_data_in;
                                    end
                                end
                            end
`ifdef SYSCTRL_HOST_IRQ_POLL_EN
                            else if (svc_q == SVC_POLL) begin
                                irq_s_q <= sys_data_in;
                            end
`endif
                        end
                        if (idx_q < len_q) begin
                            strobe_q   <= 1'b1;
                            sys_data_q <= next_byte;
                            idx_q      <= idx_q + 4'd1;
                            pay_q      <= 1'b1;
                            state_q    <= ST_BYTE;
                        end else if (is_req_frame) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
`ifdef SYSCTRL_HOST_IRQ_POLL_EN
                        else if (svc_q == SVC_POLL) begin
                            state_q <= ST_IRQ_ACK0;
                        end else begin
                            irq_valid_q  <= 1'b1;
                            irq_status_q <= irq_s_q;
                            state_q      <= ST_IRQ_ACK1;
                        end
`endif
                    end
                end
                ST_DONE: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
`ifdef SYSCTRL_HOST_IRQ_POLL_EN
                ST_IRQ_ACK0: begin
                    // Ack frame: write back the bits just read to clear them
                    len_q      <= 4'd1;
                    data_q     <= (8*MAX_LEN)'(irq_s_q);
                    idx_q      <= '0;
                    pay_q      <= 1'b0;
                    strobe_q   <= 1'b1;
                    start_q    <= 1'b1;
                    sys_data_q <= CMD_INT;
                    svc_q      <= SVC_ACK;
                    state_q    <= ST_CMD;
                end
                ST_IRQ_ACK1: begin
                    svc_q   <= SVC_NONE;
                    state_q <= ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    if (gap_end) begin
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysctrl_host.sv
// Directed bench for sysctrl_host against a small behavioural responder.
// Latency: checks strobe spacing and rsp_valid timing for STROBE_GAP=2.
// Backpressure: exercises back-to-back requests and a mid-frame reset.
module tb_sysctrl_host;
    import sysctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [3:0]  req_len;
    logic [63:0] req_data;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        sys_strobe;
    logic        sys_start;
    logic [7:0]  sys_data;
    logic [7:0]  sys_data_in = 8'h00;
    logic        sys_int_n;
    logic        irq_valid;
    logic [7:0]  irq_status;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Responder model state and link log
    int          nstb   = 0;
    int          nstart = 0;
    int          stb_cyc [32];
    logic        stb_st  [32];
    logic [7:0]  r_cmd   = 8'h00;
    int          r_pos   = 0;
    logic [7:0]  rx      [16];
    logic [1:0]  leds    = 2'b00;
    logic [7:0]  volume  = 8'h00;
    logic [3:0]  port_2  = 4'h0;
    logic [7:0]  int_status = 8'h00;

    int rsp_cnt = 0;
    int rsp_cyc = 0;
    int acc_cyc = 0;
    int nirq    = 0;
    int acc1, rsp1;

    sysctrl_host #(.STROBE_GAP(2), .MAX_LEN(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_len     (req_len),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .sys_strobe  (sys_strobe),
        .sys_start   (sys_start),
        .sys_data    (sys_data),
        .sys_data_in (sys_data_in),
        .sys_int_n   (sys_int_n),
        .irq_valid   (irq_valid),
        .irq_status  (irq_status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Responder: acts on each strobe, answers on sys_data_in well before the host samples
    always @(negedge clk) begin
        if (sys_strobe) begin
            if (nstb < 32) begin
                stb_cyc[nstb] = cyc;
                stb_st[nstb]  = sys_start;
            end
            nstb++;
            if (sys_start) begin
                nstart++;
                r_cmd = sys_data;
                r_pos = 0;
            end else begin
                if (r_pos < 16) rx[r_pos] = sys_data;
                sys_data_in = ~sys_data;
                case (r_cmd)
                    CMD_STATUS: sys_data_in = (r_pos == 0) ? STATUS_MAGIC0 :
                                              (r_pos == 1) ? STATUS_MAGIC1 :
                                              (r_pos == 2) ? 8'h02 : 8'h00;
                    CMD_LEDS:   leds = sys_data[1:0];
                    CMD_CONFIG: if (r_pos == 1) begin
                                    if (rx[0] == "A") volume = sys_data;
                                    else if (rx[0] == "J") port_2 = sys_data[3:0];
                                end
                    CMD_INT:    if (r_pos == 0) begin
                                    sys_data_in = int_status;
                                    int_status  = int_status & ~sys_data;
                                    if (int_status == 8'h00) sys_int_n = 1'b1;
                                end
                    default: ;
                endcase
                r_pos++;
            end
        end
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
        end
        if (irq_valid) nirq++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        nstb   = 0;
        nstart = 0;
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance
    task automatic send(input logic [7:0] c, input logic [3:0] l, input logic [63:0] d);
        int n;
        req_cmd   = c;
        req_len   = l;
        req_data  = d;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("accept", req_ready, 1'b1);
        acc_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("rsp_seen", rsp_cnt, target);
    endtask

    initial begin
        int n;
        int exp_rsp;
        exp_rsp   = 0;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_cmd   = 8'h00;
        req_len   = 4'd0;
        req_data  = 64'h0;
        sys_int_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 64'h0);
        chk("rst_strobe", sys_strobe, 1'b0);
        chk("rst_start", sys_start, 1'b0);
        chk("rst_data", sys_data, 8'h00);
        chk("rst_irq_valid", irq_valid, 1'b0);
        chk("rst_irq_status", irq_status, 8'h00);
        reset_n = 1'b1;
        @(negedge clk);

`ifdef SYSCTRL_HOST_IRQ_POLL_EN
        // Coldboot interrupt: poll then ack, one irq pulse, no re-poll
        clear_log();
        int_status = 8'h01;
        sys_int_n  = 1'b0;
        n = 0;
        while (nirq == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("irq_pulse", nirq, 1);
        chk("irq_status", irq_status, 8'h01);
        chk("irq_frames", nstart, 2);
        chk("irq_ack_byte", rx[0], 8'h01);
        chk("irq_int_n", sys_int_n, 1'b1);
        repeat (40) @(negedge clk);
        chk("irq_no_repoll", nstart, 2);
        chk("irq_one_pulse", nirq, 1);
        chk("irq_no_rsp", rsp_cnt, 0);
`endif

        // Status frame: magic bytes and core id, latency 1+4*3
        clear_log();
        send(CMD_STATUS, 4'd3, 64'h0);
        chk("busy_ready", req_ready, 1'b0);
        exp_rsp++;
        wait_rsp(exp_rsp);
        chk("status_data", rsp_data, 64'h0000_0000_0002_425c);
        chk("status_lat", rsp_cyc - acc_cyc, 13);
        chk("status_strobes", nstb, 4);

        // LED frame: two strobes three clocks apart, start only on the first
        clear_log();
        send(CMD_LEDS, 4'd1, 64'h03);
        exp_rsp++;
        wait_rsp(exp_rsp);
        chk("leds_value", leds, 2'b11);
        chk("leds_strobes", nstb, 2);
        chk("leds_starts", nstart, 1);
        chk("leds_start_first", stb_st[0], 1'b1);
        chk("leds_spacing", stb_cyc[1] - stb_cyc[0], 3);
        chk("leds_rsp", rsp_data, 64'hfc);
        chk("leds_hold_data", sys_data, 8'h03);

        // Back-to-back config frames
        send(CMD_CONFIG, 4'd2, 64'h0341);
        acc1 = acc_cyc;
        send(CMD_CONFIG, 4'd2, 64'h054a);
        rsp1 = rsp_cyc;
        exp_rsp += 2;
        wait_rsp(exp_rsp);
        chk("cfg_volume", volume, 8'h03);
        chk("cfg_port2", port_2, 4'b0101);
        chk("cfg_first_lat", rsp1 - acc1, 10);
        chk("cfg_b2b_accept", acc_cyc, rsp1 + 1);

        // Over-long length clamps to eight payload bytes
        clear_log();
        send(CMD_BUTTONS, 4'd12, 64'h8877_6655_4433_2211);
        exp_rsp++;
        wait_rsp(exp_rsp);
        chk("clamp_payload", nstb - 1, 8);
        chk("clamp_rsp", rsp_data, ~64'h8877_6655_4433_2211);
        chk("clamp_lat", rsp_cyc - acc_cyc, 28);

        // Reset while the first colour byte is on the link
        clear_log();
        send(CMD_COLOR, 4'd3, 64'h80);
        n = 0;
        while (nstb < 2 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("mid_reached", nstb, 2);
        reset_n = 1'b0;
        #1;
        chk("mid_strobe", sys_strobe, 1'b0);
        chk("mid_data", sys_data, 8'h00);
        chk("mid_ready", req_ready, 1'b1);
        chk("mid_rsp_data", rsp_data, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clear_log();
        send(CMD_COLOR, 4'd3, 64'h80);
        exp_rsp++;
        wait_rsp(exp_rsp);
        chk("color_cmd", r_cmd, CMD_COLOR);
        chk("color_b0", rx[0], 8'h80);
        chk("color_strobes", nstb, 4);
        chk("color_rsp", rsp_data, 64'hff_ff7f);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
